mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter_burst_line_buffer.sv | 49 ++++
 rtl/mem_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default geometry for the two-port to burst-memory arbiter.
package arb_types;
    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} arb_state_t;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned LINE_WIDTH_DEF = 256;
    localparam int unsigned BEAT_WIDTH_DEF = 64;
    localparam int unsigned NBEATS         = LINE_WIDTH_DEF / BEAT_WIDTH_DEF;
    localparam int unsigned OFFSET_BITS    = $clog2(LINE_WIDTH_DEF / 8);
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response ports plus the physical burst port, bundled.
interface mem_arbiter_if import arb_types::*; #(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [BEAT_WIDTH-1:0] pmem_wdata;
    logic [BEAT_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    // Arbiter side
    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
    // Caches + memory side
    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter_burst_line_buffer.sv
// Line buffer with beat counter: gathers read beats, serves write beats.
module burst_line_buffer import arb_types::*; #(
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [LINE_WIDTH-1:0] line_i,
    input  logic                  beat_en_i,
    input  logic                  wr_mode_i,
    input  logic [BEAT_WIDTH-1:0] rdata_i,
    output logic [LINE_WIDTH-1:0] line_o,
    output logic [BEAT_WIDTH-1:0] wbeat_o,
    output logic                  last_beat_o
);
    localparam int unsigned NB = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;

    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clear_i) begin
            cnt_d = '0;
            if (load_i) buf_d = line_i;
        end else if (beat_en_i) begin
            cnt_d = cnt_q + 1'b1;
            if (!wr_mode_i) buf_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    assign line_o      = buf_q;
    assign wbeat_o     = buf_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH];
    assign last_beat_o = (cnt_q == CW'(NB - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache and D-cache line requests onto one burst memory port.
// MEM_ARBITER_RR_EN selects round-robin grant instead of data-first priority.
module mem_arbiter import arb_types::*; #(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned OFF = $clog2(LINE_WIDTH / 8);

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_q, wr_q, i_resp_q, d_resp_q;
    logic                  grant, beat_en, last_beat, d_req, pick_d;
    logic [LINE_WIDTH-1:0] line;
    logic [BEAT_WIDTH-1:0] wbeat;

    assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARBITER_RR_EN
    logic last_d_q;  // 1: data side held the most recent grant
    assign pick_d = d_req && (!bus.i_read || !last_d_q);

    always_ff @(posedge clk) begin
        if (rst)        last_d_q <= 1'b0;
        else if (grant) last_d_q <= pick_d;
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = bus.d_write ? D_WR : D_RD;
                    addr_d  = {bus.d_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                end else if (bus.i_read) begin
                    state_d = I_RD;
                    addr_d  = {bus.i_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                end
            end
            I_RD, D_RD, D_WR: if (bus.pmem_resp && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant   = (state_q == IDLE) && (state_d != IDLE);
    assign beat_en = bus.pmem_resp && (state_q inside {I_RD, D_RD, D_WR});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_q     <= (state_d == I_RD) || (state_d == D_RD);
            wr_q     <= (state_d == D_WR);
            i_resp_q <= (state_q == I_RD) && (state_d == DONE);
            d_resp_q <= (state_q inside {D_RD, D_WR}) && (state_d == DONE);
        end
    end

    burst_line_buffer #(.LINE_WIDTH(LINE_WIDTH), .BEAT_WIDTH(BEAT_WIDTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (grant),
        .load_i     (state_d == D_WR),
        .line_i     (bus.d_wdata),
        .beat_en_i  (beat_en),
        .wr_mode_i  (state_q == D_WR),
        .rdata_i    (bus.pmem_rdata),
        .line_o     (line),
        .wbeat_o    (wbeat),
        .last_beat_o(last_beat)
    );

    assign bus.i_rdata      = line;
    assign bus.d_rdata      = line;
    assign bus.i_resp       = i_resp_q;
    assign bus.d_resp       = d_resp_q;
    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wbeat;
endmodule
